// File: rtl/dec_aes.sv
// dec_aes: iterative AES-128 inverse cipher.
//
// Takes one ciphertext block and a cipher key. It first runs the key schedule
// forward to the last round key. It then applies one inverse round per clock
// while it steps the key schedule backwards. The plaintext comes out on
// outStream, together with a one-cycle out_valid pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while in_ready=1
//   in_ready  high while idle
//   inStream  128-bit ciphertext, byte 0 = [127:120], column-major state
//   key       128-bit cipher key, same byte order
//   outStream 128-bit plaintext, held until the next result
//   out_valid one-cycle pulse when outStream updates
//
// The S-boxes are computed arithmetically rather than from tables: a GF(2^8)
// inverse (a^254) combined with the affine transform or its inverse.

// Multiplicative inverse in GF(2^8) mod 0x11b, via a^254 (0 maps to 0).
module dec_aes_gf_inv (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;

  always_comb begin
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a6   = gmul(a3, a3);
    a12  = gmul(a6, a6);
    a15  = gmul(a12, a3);
    a30  = gmul(a15, a15);
    a60  = gmul(a30, a30);
    a120 = gmul(a60, a60);
    a240 = gmul(a120, a120);
    // 254 = 240 + 12 + 2
    y    = gmul(gmul(a240, a12), a2);
  end
endmodule

// Forward S-box: inverse followed by the affine transform.
module dec_aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] b;

  dec_aes_gf_inv u_inv (.a(a), .y(b));

  assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the field inverse.
module dec_aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] t;

  assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

  dec_aes_gf_inv u_inv (.a(t), .y(y));
endmodule

module dec_aes #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         in_ready,
  input  logic [127:0] inStream,
  input  logic [127:0] key,
  output logic [127:0] outStream,
  output logic         out_valid
);
  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, FINAL} state_t;

  state_t       state_reg, state_next;
  logic [127:0] blk_reg, blk_next;
  logic [127:0] rk_reg, rk_next;
  logic [127:0] out_reg, out_next;
  logic [3:0]   rcnt_reg, rcnt_next;
  logic         out_valid_reg, out_valid_next;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // ---------------- round datapath ----------------
  logic [127:0] isr;        // InvShiftRows(blk)
  logic [127:0] isb;        // InvSubBytes(isr)
  logic [127:0] round_add;  // isb ^ round key
  logic [127:0] inv_mix;    // InvMixColumns(round_add)

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      // Row r rotates right by r: the output column c takes column c-r.
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);

      assign isr[127-8*gi -: 8] = blk_reg[127-8*SRC -: 8];

      dec_aes_inv_sbox u_isb (.a(isr[127-8*gi -: 8]), .y(isb[127-8*gi -: 8]));
    end
  endgenerate

  assign round_add = isb ^ rk_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign inv_mix[127-32*gi -: 32] = inv_mix_col(round_add[127-32*gi -: 32]);
    end
  endgenerate

  // ---------------- key schedule, both directions ----------------
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] inv_w1, inv_w2, inv_w3;
  logic [31:0] sub_in, rot_in, sub_out, kt;
  logic [31:0] f0, f1, f2, f3;
  logic [3:0]  rcon_idx;
  logic [127:0] rk_fwd, rk_prev;

  assign {w0, w1, w2, w3} = rk_reg;
  assign inv_w3 = w3 ^ w2;
  assign inv_w2 = w2 ^ w1;
  assign inv_w1 = w1 ^ w0;

  // One SubWord unit serves both directions. Forward expansion feeds it w3.
  // The backward step feeds it the recovered previous w3.
  assign sub_in = (state_reg == KEXP) ? w3 : inv_w3;
  assign rot_in = {sub_in[23:0], sub_in[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      dec_aes_sbox u_sb (.a(rot_in[31-8*gi -: 8]), .y(sub_out[31-8*gi -: 8]));
    end
  endgenerate

  // The counter has already run past NR when the first backward step happens.
  assign rcon_idx = (state_reg == ADDK) ? NR_L : rcnt_reg;
  assign kt       = sub_out ^ {rcon(rcon_idx), 24'h0};

  assign f0 = w0 ^ kt;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign rk_fwd  = {f0, f1, f2, f3};
  assign rk_prev = {w0 ^ kt, inv_w1, inv_w2, inv_w3};

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      blk_reg       <= '0;
      rk_reg        <= '0;
      out_reg       <= '0;
      rcnt_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      blk_reg       <= blk_next;
      rk_reg        <= rk_next;
      out_reg       <= out_next;
      rcnt_reg      <= rcnt_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    blk_next       = blk_reg;
    rk_next        = rk_reg;
    out_next       = out_reg;
    rcnt_next      = rcnt_reg;
    out_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          blk_next   = inStream;
          rk_next    = key;
          rcnt_next  = 4'd1;
          state_next = KEXP;
        end
      end
      KEXP: begin
        rk_next   = rk_fwd;
        rcnt_next = rcnt_reg + 4'd1;
        if (rcnt_reg == NR_L) state_next = ADDK;
      end
      ADDK: begin
        blk_next   = blk_reg ^ rk_reg;
        rk_next    = rk_prev;
        rcnt_next  = NR_L - 4'd1;
        state_next = ROUND;
      end
      ROUND: begin
        blk_next  = inv_mix;
        rk_next   = rk_prev;
        rcnt_next = rcnt_reg - 4'd1;
        if (rcnt_reg == 4'd1) state_next = FINAL;
      end
      FINAL: begin
        out_next       = round_add;
        out_valid_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign outStream = out_reg;
  assign out_valid = out_valid_reg;
endmodule
